// File: rtl/bram_rw_pkg.sv
// Shared definitions for the walker BRAM port: default widths, table layout
// offsets, arbiter state encoding and a width helper.
package bram_rw_pkg;

  localparam int ADDR_WIDTH_DEF = 13;
  localparam int DATA_WIDTH_DEF = 32;

  localparam int NEI_ADDR_TABLE_OFFSET = 10;
  localparam int NEI_TABLE_OFFSET      = 100;
  localparam int SCORE_TABLE_OFFSET    = 1000;

  typedef enum logic [0:0] {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first set request at or above ptr,
// wrapping from N-1 back to 0.
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic found;
  int   cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin owner of the single walker BRAM port with locked sequences
// for atomic read-modify-write; read data is tagged back to the issuer.
//
// state     | meaning
// ST_ARB    | round-robin grant among all valid requesters
// ST_LOCKED | only the owner may be granted, everyone else waits
module bram_port_arbiter
  import bram_rw_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic                          bram_we,
  output logic [DATA_WIDTH-1:0]         bram_din,
  input  logic [DATA_WIDTH-1:0]         bram_dout
);

  localparam int TAG_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
  localparam int DEPTH = 1 + RD_LATENCY;

  if (RD_LATENCY < 1) begin : g_bad_latency
    $error("bram_port_arbiter: RD_LATENCY must be at least 1");
  end
  if (SCORE_TABLE_OFFSET >= (1 << ADDR_WIDTH)) begin : g_bad_layout
    $error("bram_port_arbiter: table layout does not fit the address space");
  end

  arb_state_t        state;
  logic [TAG_W-1:0]  ptr;
  logic [TAG_W-1:0]  owner;
  logic [TAG_W-1:0]  pick_idx;
  logic [TAG_W-1:0]  acc_idx;
  logic [TAG_W-1:0]  nxt_ptr;
  logic [NUM_REQ-1:0] pick_grant;
  logic              accept;
  logic [DEPTH-1:0]  pipe_v;
  logic [TAG_W-1:0]  pipe_tag [DEPTH];

  rr_priority_picker #(.N(NUM_REQ), .IW(TAG_W)) u_picker (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_comb begin
    req_ready = '0;
    acc_idx   = (state == ST_LOCKED) ? owner : pick_idx;
    if (!rst) begin
      if (state == ST_ARB) req_ready = pick_grant;
      else                 req_ready[owner] = req_valid[owner];
    end
  end

  assign accept  = |(req_valid & req_ready);
  assign nxt_ptr = (int'(acc_idx) == NUM_REQ - 1) ? '0 : acc_idx + TAG_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ARB;
      ptr       <= '0;
      owner     <= '0;
      bram_addr <= '0;
      bram_we   <= 1'b0;
      bram_din  <= '0;
      pipe_v    <= '0;
      for (int k = 0; k < DEPTH; k++) pipe_tag[k] <= '0;
    end else begin
      bram_we     <= accept & req_we[acc_idx];
      // Tag stage 0 holds the issue cycle; the last stage lines up with bram_dout.
      pipe_v      <= {pipe_v[DEPTH-2:0], accept & ~req_we[acc_idx]};
      pipe_tag[0] <= acc_idx;
      for (int k = 1; k < DEPTH; k++) pipe_tag[k] <= pipe_tag[k-1];
      if (accept) begin
        bram_addr <= req_addr[int'(acc_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        bram_din  <= req_wdata[int'(acc_idx)*DATA_WIDTH +: DATA_WIDTH];
        ptr       <= nxt_ptr;
        if (req_lock[acc_idx]) begin
          state <= ST_LOCKED;
          owner <= acc_idx;
        end else begin
          state <= ST_ARB;
        end
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (pipe_v[DEPTH-1]) rsp_valid[pipe_tag[DEPTH-1]] = 1'b1;
  end

  assign rsp_data = bram_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed scenarios plus a randomized run,
// all checked against a queue-based reference model and a BRAM behavioural model.
module tb_bram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_data, bram_din, bram_dout;
  logic [AW-1:0] bram_addr;
  logic          bram_we;

  always #5 clk = ~clk;

  bram_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bram_addr(bram_addr), .bram_we(bram_we), .bram_din(bram_din), .bram_dout(bram_dout)
  );

  logic [DW-1:0] bram [0:(1<<AW)-1];
  logic [DW-1:0] dpipe [RL];
  always @(posedge clk) begin
    if (bram_we) bram[bram_addr] <= bram_din;
    dpipe[0] <= bram[bram_addr];
    for (int k = 1; k < RL; k++) dpipe[k] <= dpipe[k-1];
  end
  assign bram_dout = dpipe[RL-1];

  // Reference model
  int n_vec = 0, n_err = 0, cyc = 0;
  int m_ptr = 0, m_owner = 0, last_g = -1;
  bit m_locked = 1'b0;
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  typedef struct { int due; int eng; logic [DW-1:0] data; } rsp_t;
  rsp_t pend[$];
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_din, exp_rd;
  logic [N-1:0]  exp_rv;

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (rst) return r;
    if (m_locked) begin
      if (req_valid[m_owner]) r[m_owner] = 1'b1;
      return r;
    end
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req_valid[j]) begin
        r[j] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic clk_step();
    logic [N-1:0] g;
    int gi;
    g  = exp_ready();
    gi = -1;
    for (int k = 0; k < N; k++) if (g[k]) gi = k;
    @(posedge clk);
    cyc++;
    last_g = gi;
    if (rst) begin
      m_ptr = 0; m_locked = 1'b0; pend.delete();
      exp_we = 1'b0; exp_addr = '0; exp_din = '0; last_g = -1;
    end else begin
      exp_we = 1'b0;
      if (gi >= 0) begin
        exp_addr = req_addr[gi*AW +: AW];
        exp_we   = req_we[gi];
        if (req_we[gi]) begin
          exp_din = req_wdata[gi*DW +: DW];
          shadow[exp_addr] = exp_din;
        end else begin
          pend.push_back('{cyc + RL, gi, shadow[exp_addr]});
        end
        m_ptr    = (gi + 1) % N;
        m_locked = req_lock[gi];
        m_owner  = gi;
      end
    end
    exp_rv = '0; exp_rd = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_rv[pend[0].eng] = 1'b1;
      exp_rd = pend[0].data;
      void'(pend.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input bit v, input bit we, input bit lk,
                         input int addr, input logic [DW-1:0] d);
    req_valid[i] = v; req_we[i] = we; req_lock[i] = lk;
    req_addr[i*AW +: AW] = AW'(addr);
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic idle_all();
    req_valid = '0; req_we = '0; req_lock = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle_all();
    clk_step(); clk_step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1, 0, 0, 5, '0);
    #1;
    n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL reset.ready got=%b exp=0000", req_ready); end
    clk_step(); clk_step();
    n_vec++; if (bram_we !== 1'b0 || bram_addr !== '0 || bram_din !== '0) begin
      n_err++; $display("FAIL reset.bram got we=%b addr=%h din=%h exp 0/0/0", bram_we, bram_addr, bram_din); end
    n_vec++; if (rsp_valid !== '0) begin n_err++; $display("FAIL reset.rsp_valid got=%b exp=0000", rsp_valid); end
    idle_all(); rst = 1'b0;
    clk_step();
  endtask

  task automatic test_single_read();
    set_req(0, 1, 1, 0, 5, 32'hDEADBEEF); #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single.wr_ready got=%b exp=0001", req_ready); end
    clk_step();
    n_vec++; if (bram_we !== 1'b1 || bram_addr !== 13'h005 || bram_din !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL single.wr_issue got we=%b addr=%h din=%h exp 1/005/deadbeef", bram_we, bram_addr, bram_din); end
    set_req(0, 1, 0, 0, 5, '0); #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single.rd_ready got=%b exp=0001", req_ready); end
    clk_step(); idle_all();
    n_vec++; if (bram_we !== 1'b0 || bram_addr !== 13'h005 || rsp_valid !== '0) begin
      n_err++; $display("FAIL single.rd_issue got we=%b addr=%h rv=%b exp 0/005/0000", bram_we, bram_addr, rsp_valid); end
    clk_step();
    n_vec++; if (rsp_valid !== 4'b0001 || rsp_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL single.rsp got rv=%b data=%h exp 0001/deadbeef", rsp_valid, rsp_data); end
    clk_step();
    n_vec++; if (rsp_valid !== '0) begin n_err++; $display("FAIL single.rsp_once got=%b exp=0000", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] e;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1, 0, 0, 5, '0);
    for (int k = 0; k < 8; k++) begin
      #1;
      e = N'(1 << (k % N));
      n_vec++; if (req_ready !== e) begin n_err++; $display("FAIL rr.grant[%0d] got=%b exp=%b", k, req_ready, e); end
      clk_step();
      if (k > 0) begin
        e = N'(1 << ((k - 1) % N));
        n_vec++; if (rsp_valid !== e || rsp_data !== 32'hDEADBEEF) begin
          n_err++; $display("FAIL rr.rsp[%0d] got rv=%b data=%h exp %b/deadbeef", k, rsp_valid, rsp_data, e); end
      end
    end
    idle_all();
    clk_step();
    n_vec++; if (rsp_valid !== 4'b1000) begin n_err++; $display("FAIL rr.rsp_last got=%b exp=1000", rsp_valid); end
  endtask

  task automatic test_locked_rmw();
    logic [N-1:0] rdy;
    int phase;
    set_req(1, 1, 1, 0, 'h64, 32'd7);
    clk_step(); idle_all();
    for (int i = 0; i < N; i++) set_req(i, 1, 0, i == 1, (i == 1) ? 'h64 : 5, '0);
    phase = 0;
    for (int c = 0; c < 20 && phase != 3; c++) begin
      #1; rdy = req_ready;
      n_vec++; if (rdy !== exp_ready()) begin n_err++; $display("FAIL rmw.ready c%0d got=%b exp=%b", c, rdy, exp_ready()); end
      if (phase == 1 || phase == 2) begin
        n_vec++; if ((rdy & 4'b1101) !== '0) begin n_err++; $display("FAIL rmw.intruder c%0d got=%b exp=00x0", c, rdy); end
      end
      clk_step();
      n_vec++; if (rsp_valid !== exp_rv) begin n_err++; $display("FAIL rmw.rsp_valid c%0d got=%b exp=%b", c, rsp_valid, exp_rv); end
      if (phase == 0 && rdy[1]) begin
        phase = 1; req_valid[1] = 1'b0;
      end else if (phase == 1 && rsp_valid[1]) begin
        n_vec++; if (rsp_data !== 32'd7) begin n_err++; $display("FAIL rmw.read got=%h exp=00000007", rsp_data); end
        set_req(1, 1, 1, 0, 'h64, rsp_data + 32'd1);
        phase = 2;
      end else if (phase == 2 && rdy[1]) begin
        phase = 3; req_valid[1] = 1'b0;
      end
    end
    n_vec++; if (phase != 3) begin n_err++; $display("FAIL rmw.timeout got phase=%0d exp=3", phase); end
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rmw.next_grant got=%b exp=0100", req_ready); end
    idle_all();
    clk_step(); clk_step(); clk_step();
    n_vec++; if (bram[13'h064] !== 32'd8) begin n_err++; $display("FAIL rmw.mem got=%h exp=00000008", bram[13'h064]); end
  endtask

  task automatic test_owner_idle();
    set_req(2, 1, 0, 1, 'h64, '0); #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL idle.lock_ready got=%b exp=0100", req_ready); end
    clk_step();
    req_valid[2] = 1'b0;
    set_req(0, 1, 0, 0, 5, '0);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL idle.wait c%0d got=%b exp=0000", c, req_ready); end
      clk_step();
    end
    set_req(2, 1, 1, 0, 'h64, 32'd9); #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL idle.release got=%b exp=0100", req_ready); end
    clk_step();
    req_valid[2] = 1'b0; #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL idle.after got=%b exp=0001", req_ready); end
    clk_step(); idle_all();
    clk_step(); clk_step();
  endtask

  task automatic test_write_then_read();
    set_req(3, 1, 1, 0, 'h1FFF, 32'hA5A5A5A5); #1;
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL wtr.wr_ready got=%b exp=1000", req_ready); end
    clk_step();
    set_req(3, 1, 0, 0, 'h1FFF, '0);
    n_vec++; if (bram_we !== 1'b1 || bram_addr !== 13'h1FFF || bram_din !== 32'hA5A5A5A5) begin
      n_err++; $display("FAIL wtr.wr_issue got we=%b addr=%h din=%h exp 1/1fff/a5a5a5a5", bram_we, bram_addr, bram_din); end
    #1;
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL wtr.rd_ready got=%b exp=1000", req_ready); end
    clk_step(); idle_all();
    n_vec++; if (bram_we !== 1'b0 || rsp_valid !== '0) begin
      n_err++; $display("FAIL wtr.we_pulse got we=%b rv=%b exp 0/0000", bram_we, rsp_valid); end
    clk_step();
    n_vec++; if (rsp_valid !== 4'b1000 || rsp_data !== 32'hA5A5A5A5) begin
      n_err++; $display("FAIL wtr.rsp got rv=%b data=%h exp 1000/a5a5a5a5", rsp_valid, rsp_data); end
    clk_step();
  endtask

  task automatic test_reset_mid_read();
    set_req(0, 1, 0, 0, 5, '0); #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rstmid.ready got=%b exp=0001", req_ready); end
    clk_step(); idle_all();
    rst = 1'b1;
    clk_step();
    n_vec++; if (rsp_valid !== '0 || bram_we !== 1'b0 || bram_addr !== '0) begin
      n_err++; $display("FAIL rstmid.drop got rv=%b we=%b addr=%h exp 0000/0/000", rsp_valid, bram_we, bram_addr); end
    rst = 1'b0;
    clk_step();
    n_vec++; if (rsp_valid !== '0) begin n_err++; $display("FAIL rstmid.late got=%b exp=0000", rsp_valid); end
    for (int i = 0; i < N; i++) set_req(i, 1, 0, 0, 5, '0);
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rstmid.first got=%b exp=0001", req_ready); end
    clk_step(); idle_all();
    clk_step(); clk_step();
  endtask

  task automatic test_random();
    do_reset();
    for (int a = 0; a < 16; a++) begin
      set_req(0, 1, 1, 0, a, $urandom);
      clk_step();
    end
    idle_all();
    clk_step();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_g == i)
          set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 15), $urandom);
      end
      #1;
      n_vec++; if (req_ready !== exp_ready()) begin n_err++; $display("FAIL rand.ready c%0d got=%b exp=%b", c, req_ready, exp_ready()); end
      clk_step();
      n_vec++; if (bram_we !== exp_we) begin n_err++; $display("FAIL rand.we c%0d got=%b exp=%b", c, bram_we, exp_we); end
      if (last_g >= 0) begin
        n_vec++; if (bram_addr !== exp_addr) begin n_err++; $display("FAIL rand.addr c%0d got=%h exp=%h", c, bram_addr, exp_addr); end
      end
      if (exp_we) begin
        n_vec++; if (bram_din !== exp_din) begin n_err++; $display("FAIL rand.din c%0d got=%h exp=%h", c, bram_din, exp_din); end
      end
      n_vec++; if (rsp_valid !== exp_rv) begin n_err++; $display("FAIL rand.rsp_valid c%0d got=%b exp=%b", c, rsp_valid, exp_rv); end
      if (exp_rv != '0) begin
        n_vec++; if (rsp_data !== exp_rd) begin n_err++; $display("FAIL rand.rsp_data c%0d got=%h exp=%h", c, rsp_data, exp_rd); end
      end
    end
    idle_all();
    for (int c = 0; c < 3; c++) begin
      clk_step();
      n_vec++; if (rsp_valid !== exp_rv) begin n_err++; $display("FAIL rand.drain c%0d got=%b exp=%b", c, rsp_valid, exp_rv); end
    end
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) shadow[a] = '0;
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    exp_we = 1'b0; exp_addr = '0; exp_din = '0; exp_rd = '0; exp_rv = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_locked_rmw();
    test_owner_idle();
    test_write_then_read();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the single 13-bit-address, 32-bit-data BRAM port between NUM_REQ random-walk engines.
- Grants one access per cycle, round-robin.
- Supports locked sequences, so an engine's counter read-modify-write (read counter, write counter+1) is atomic.
- Sits between the walker engines and the BRAM. It is the only driver of BRAM address, write-enable and data-in.

Parameters:
NUM_REQ, 4, number of requesting walker engines
ADDR_WIDTH, 13, BRAM address width
DATA_WIDTH, 32, BRAM data width
RD_LATENCY, 1, BRAM cycles from registered address to valid dout (1..3)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-engine request
req_ready  out  NUM_REQ  one-hot grant; accept = req_valid[i] & req_ready[i]
req_we  in  NUM_REQ  1 = write, 0 = read
req_lock  in  NUM_REQ  1 = keep ownership after this access
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, engine i at slice i
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
rsp_valid  out  NUM_REQ  read data valid for engine i
rsp_data  out  DATA_WIDTH  read data, shared by all engines
bram_addr  out  ADDR_WIDTH  registered BRAM address
bram_we  out  1  registered BRAM write enable
bram_din  out  DATA_WIDTH  registered BRAM write data
bram_dout  in  DATA_WIDTH  BRAM read data

Behaviour:
- Reset values:
  - bram_addr=0, bram_we=0, bram_din=0, rsp_valid=0.
  - RR pointer=0, FSM=ARB.
  - Response tag pipeline cleared.
  - req_ready=0 while rst=1.
- req_ready is combinational from req_valid, FSM state and pointer. At most one bit is set. It is never set unless the matching req_valid is set.
- FSM ARB:
  - Grant the first requester with req_valid=1, searching from ptr upward with wrap at NUM_REQ-1 -> 0.
  - On accept of engine g: ptr <= (g+1) mod NUM_REQ.
  - If req_lock[g]=1: owner <= g and go to LOCKED.
- FSM LOCKED:
  - Only the owner can be granted. Other engines wait, even when the owner is idle; there is no timeout.
  - On an owner accept with req_lock=0: go to ARB, ptr <= (owner+1) mod NUM_REQ.
  - On an owner accept with req_lock=1: stay LOCKED.
- Issue timing:
  - Accept at clock edge t: bram_addr/bram_we/bram_din carry the request during cycle t+1.
  - bram_we is high for exactly that one cycle, and only for writes.
  - With no accept, bram_we=0 and bram_addr holds its last value.
- Read response:
  - The engine index of an accepted read travels through a (1+RD_LATENCY)-deep valid/tag shift register.
  - rsp_valid[i] pulses for one cycle, 1+RD_LATENCY cycles after the accept edge.
  - rsp_data = bram_dout (combinational pass-through) in that cycle. Outside that cycle rsp_data is don't-care.
- Writes produce no response.
- Throughput: one accept per cycle, with back-to-back accepts allowed. Read responses come back in issue order.
- Ordering: a read accepted the cycle after a write to the same address returns the new data, because BRAM accesses are serialised one per cycle.
- Simultaneous events: a new accept and a response in the same cycle are independent. A lock release and a new ARB grant never happen in the same cycle; the next grant comes on the following cycle.
- Requester behaviour on stall: an engine holds req_* stable while req_valid=1 and req_ready=0. The arbiter does not check this.
- Reset mid-operation: in-flight responses are dropped (no rsp_valid), lock is released, and bram_we is forced to 0 on the reset cycle.
- Illegal parameter: RD_LATENCY=0 is unsupported and fails an elaboration check.

Decomposition:
- Shared package bram_rw_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH defaults.
  - Table offsets NEI_ADDR_TABLE_OFFSET=10, NEI_TABLE_OFFSET=100, SCORE_TABLE_OFFSET=1000.
  - FSM state encoding (ARB, LOCKED).
  - Function clog2 for tag width.
- Sub-module rr_priority_picker:
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and index.
  - Purely combinational; the pointer register stays in bram_port_arbiter.

Test Plan:
- Single read: BRAM[0x005]=0xDEADBEEF, engine 0 reads 0x005 -> req_ready[0]=1 the same cycle; bram_addr=0x005 and bram_we=0 the next cycle; rsp_valid[0]=1 with rsp_data=0xDEADBEEF exactly 2 cycles after accept (RD_LATENCY=1).
- Round-robin: all 4 engines hold read requests for 8 cycles -> grant sequence 0,1,2,3,0,1,2,3, one grant per cycle; responses tagged in the same order.
- Locked RMW: engine 1 reads 0x064 with lock=1 (returns 7), then writes 8 with lock=0, while engines 0, 2 and 3 request continuously -> no other grant between the two; BRAM[0x064]=8; the next grant goes to engine 2.
- Write-then-read: engine 3 writes 0x1FFF=0xA5A5A5A5, then engine 3 reads 0x1FFF -> bram_we high exactly 1 cycle, no response for the write; read returns 0xA5A5A5A5.
- Owner idle while locked: engine 2 takes lock, drops req_valid for 5 cycles while engine 0 requests -> req_ready stays 0 for all 5 cycles; engine 0 is granted one cycle after engine 2's lock=0 access.
- Reset mid-read: rst=1 on the cycle after engine 0's read accept -> rsp_valid stays 0; bram_we=0; ptr=0, so engine 0 wins first when all request after reset.
